// File: rtl/chronos_mem_pkg.sv
// Shared definitions for the load/store path: memory commands, RV32I opcode and
// funct3 encodings, controller state and request decode helpers.
package chronos_mem_pkg;

  localparam logic MEM_CMD_READ  = 1'b0;
  localparam logic MEM_CMD_WRITE = 1'b1;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } mac_state_e;

  function automatic logic req_legal(input logic [6:0] op, input logic [2:0] f3);
    if (op == OP_LOAD)
      return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) || (f3 == F3_BU) || (f3 == F3_HU);
    if (op == OP_STORE)
      return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
    return 1'b0;
  endfunction

  // Width comes from funct3[1:0] for both loads and stores (B/BU, H/HU, W).
  function automatic logic req_misaligned(input logic [2:0] f3, input logic [1:0] lo);
    case (f3[1:0])
      2'b01:   return lo[0];
      2'b10:   return lo != 2'b00;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/load_align.sv
// Picks the addressed byte/half out of a memory word and sign- or zero-extends
// it according to the load funct3. Purely combinational.
module load_align
  import chronos_mem_pkg::*;
(
  input  logic [2:0]  i_funct3,
  input  logic [1:0]  i_addr_lo,
  input  logic [31:0] i_word,
  output logic [31:0] o_data
);

  logic [31:0] w_shift;
  logic [7:0]  w_byte;
  logic [15:0] w_half;

  assign w_shift = i_word >> {i_addr_lo, 3'b000};
  assign w_byte  = w_shift[7:0];
  assign w_half  = i_addr_lo[1] ? i_word[31:16] : i_word[15:0];

  always_comb begin
    o_data = i_word;
    case (i_funct3)
      F3_B:    o_data = {{24{w_byte[7]}}, w_byte};
      F3_BU:   o_data = {24'h0, w_byte};
      F3_H:    o_data = {{16{w_half[15]}}, w_half};
      F3_HU:   o_data = {16'h0, w_half};
      default: o_data = i_word;
    endcase
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// Load/store initiator: latches one request, drives the mem responder until
// mem_valid or timeout, then returns one response pulse.
module mem_access_ctrl
  import chronos_mem_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_req_valid,
  output logic        o_req_ready,
  input  logic [31:0] i_req_instr,
  input  logic [31:0] i_req_addr,
  input  logic [31:0] i_req_store_data,
  output logic        o_resp_valid,
  output logic [31:0] o_resp_load_data,
  output logic        o_resp_error,
  output logic [31:0] o_mem_addr,
  output logic [3:0]  o_mem_write_mask,
  output logic        o_mem_enable,
  output logic        o_mem_cmd,
  output logic [31:0] o_mem_write_data,
  input  logic [31:0] i_mem_load_data,
  input  logic        i_mem_valid
);

  localparam int CNT_W = ($clog2(TIMEOUT_CYCLES) > 8) ? $clog2(TIMEOUT_CYCLES) : 8;

  mac_state_e  r_state;
  logic [2:0]  r_f3;
  logic [31:0] r_addr;
  logic        r_is_store;
  logic [3:0]  r_mask;
  logic [31:0] r_wdata;
  logic [CNT_W-1:0] r_cnt;
  logic [31:0] r_resp_data;
  logic        r_resp_err;

  logic [6:0]  w_op;
  logic [2:0]  w_f3;
  logic        w_store;
  logic        w_ok;
  logic [3:0]  w_mask;
  logic [31:0] w_wdata;
  logic [31:0] w_load;

  assign w_op    = i_req_instr[6:0];
  assign w_f3    = i_req_instr[14:12];
  assign w_store = (w_op == OP_STORE);
  assign w_ok    = req_legal(w_op, w_f3) && !req_misaligned(w_f3, i_req_addr[1:0]);

  // Byte lanes and replicated data are fixed at accept so ACCESS outputs stay stable.
  always_comb begin
    w_mask  = 4'b1111;
    w_wdata = 32'h0;
    if (w_store) begin
      case (w_f3)
        F3_B: begin
          w_mask  = 4'b0001 << i_req_addr[1:0];
          w_wdata = {4{i_req_store_data[7:0]}};
        end
        F3_H: begin
          w_mask  = 4'b0011 << i_req_addr[1:0];
          w_wdata = {2{i_req_store_data[15:0]}};
        end
        default: w_wdata = i_req_store_data;
      endcase
    end
  end

  load_align u_load_align (
    .i_funct3  (r_f3),
    .i_addr_lo (r_addr[1:0]),
    .i_word    (i_mem_load_data),
    .o_data    (w_load)
  );

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state     <= ST_IDLE;
      r_f3        <= 3'b0;
      r_addr      <= 32'h0;
      r_is_store  <= 1'b0;
      r_mask      <= 4'b0;
      r_wdata     <= 32'h0;
      r_cnt       <= '0;
      r_resp_data <= 32'h0;
      r_resp_err  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: if (i_req_valid) begin
          r_f3       <= w_f3;
          r_addr     <= i_req_addr;
          r_is_store <= w_store;
          r_mask     <= w_mask;
          r_wdata    <= w_wdata;
          r_cnt      <= '0;
          if (w_ok) begin
            r_state <= ST_ACCESS;
          end else begin
            r_state     <= ST_RESP;
            r_resp_err  <= 1'b1;
            r_resp_data <= 32'h0;
          end
        end
        ST_ACCESS: begin
          // mem_valid wins over an expiring counter on the same cycle.
          if (i_mem_valid) begin
            r_state     <= ST_RESP;
            r_resp_err  <= 1'b0;
            r_resp_data <= r_is_store ? 32'h0 : w_load;
          end else if (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
            r_state     <= ST_RESP;
            r_resp_err  <= 1'b1;
            r_resp_data <= 32'h0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        ST_RESP: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_req_ready      = (r_state == ST_IDLE);
  assign o_resp_valid     = (r_state == ST_RESP);
  assign o_resp_load_data = r_resp_data;
  assign o_resp_error     = r_resp_err;
  assign o_mem_enable     = (r_state == ST_ACCESS);
  assign o_mem_addr       = {r_addr[31:2], 2'b00};
  assign o_mem_write_mask = r_mask;
  assign o_mem_cmd        = r_is_store ? MEM_CMD_WRITE : MEM_CMD_READ;
  assign o_mem_write_data = r_wdata;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench for mem_access_ctrl: directed cases plus randomized
// requests checked against an arithmetic reference model.
module tb_mem_access_ctrl;

  localparam int T = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [31:0] req_instr = 32'h0;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_store_data = 32'h0;
  logic        resp_valid;
  logic [31:0] resp_load_data;
  logic        resp_error;
  logic [31:0] mem_addr;
  logic [3:0]  mem_write_mask;
  logic        mem_enable;
  logic        mem_cmd;
  logic [31:0] mem_write_data;
  logic [31:0] mem_load_data = 32'h0;
  logic        mem_valid = 1'b0;

  int n_cmp = 0;
  int n_err = 0;

  mem_access_ctrl #(.TIMEOUT_CYCLES(T)) dut (
    .i_clk(clk), .i_reset(reset),
    .i_req_valid(req_valid), .o_req_ready(req_ready),
    .i_req_instr(req_instr), .i_req_addr(req_addr), .i_req_store_data(req_store_data),
    .o_resp_valid(resp_valid), .o_resp_load_data(resp_load_data), .o_resp_error(resp_error),
    .o_mem_addr(mem_addr), .o_mem_write_mask(mem_write_mask), .o_mem_enable(mem_enable),
    .o_mem_cmd(mem_cmd), .o_mem_write_data(mem_write_data),
    .i_mem_load_data(mem_load_data), .i_mem_valid(mem_valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference model: plain arithmetic on the instruction fields.
  function automatic bit m_is_load(input logic [31:0] ins);
    return ins[6:0] == 7'h03;
  endfunction
  function automatic bit m_is_store(input logic [31:0] ins);
    return ins[6:0] == 7'h23;
  endfunction
  function automatic bit m_error(input logic [31:0] ins, input logic [31:0] a);
    int f3;
    int size;
    f3 = int'(ins[14:12]);
    if (m_is_load(ins))       begin if (!(f3 inside {0, 1, 2, 4, 5})) return 1; end
    else if (m_is_store(ins)) begin if (!(f3 inside {0, 1, 2})) return 1; end
    else return 1;
    size = (f3 % 4 == 0) ? 1 : (f3 % 4 == 1) ? 2 : 4;
    return (a % size) != 0;
  endfunction
  function automatic logic [31:0] m_load(input logic [31:0] ins, input logic [31:0] a, input logic [31:0] w);
    int f3;
    logic [31:0] v;
    f3 = int'(ins[14:12]);
    case (f3)
      0, 4: begin
        v = (w >> (8 * (a % 4))) & 32'hFF;
        if (f3 == 0 && v >= 32'h80) v = v | 32'hFFFFFF00;
      end
      1, 5: begin
        v = (w >> (8 * (a % 4))) & 32'hFFFF;
        if (f3 == 1 && v >= 32'h8000) v = v | 32'hFFFF0000;
      end
      default: v = w;
    endcase
    return v;
  endfunction
  function automatic logic [31:0] m_mask(input logic [31:0] ins, input logic [31:0] a);
    if (m_is_load(ins) || ins[14:12] == 3'd2) return 32'hF;
    if (ins[14:12] == 3'd0) return 32'h1 << (a % 4);
    return 32'h3 << (a % 4);
  endfunction
  function automatic logic [31:0] m_wdata(input logic [31:0] ins, input logic [31:0] d);
    if (ins[14:12] == 3'd0) return (d & 32'hFF) * 32'h01010101;
    if (ins[14:12] == 3'd1) return (d & 32'hFFFF) * 32'h00010001;
    return d;
  endfunction

  function automatic logic [31:0] mk(input logic [6:0] op, input logic [2:0] f3);
    logic [31:0] ins;
    ins = $urandom();
    ins[6:0] = op;
    ins[14:12] = f3;
    return ins;
  endfunction

  // One full transaction; waits >= T means mem never answers.
  task automatic run(input string tag, input logic [31:0] ins, input logic [31:0] a,
                     input logic [31:0] sd, input int waits, input logic [31:0] w);
    bit e;
    int n_en;
    logic [31:0] exp_d;
    e = m_error(ins, a);
    @(negedge clk);
    chk({tag, ".ready"}, 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_instr = ins; req_addr = a; req_store_data = sd;
    @(negedge clk);
    req_valid = 1'b0;
    n_en = 0;
    for (int i = 0; i < T + 4; i++) begin
      if (mem_enable !== 1'b1) break;
      n_en++;
      if (i == 0) begin
        chk({tag, ".not_ready"}, 32'(req_ready), 32'd0);
        chk({tag, ".addr"}, mem_addr, a & 32'hFFFFFFFC);
        chk({tag, ".mask"}, 32'(mem_write_mask), m_mask(ins, a));
        chk({tag, ".cmd"}, 32'(mem_cmd), 32'(m_is_store(ins)));
        if (m_is_store(ins)) chk({tag, ".wdata"}, mem_write_data, m_wdata(ins, sd));
      end
      if (i == waits) begin mem_valid = 1'b1; mem_load_data = w; end
      @(negedge clk);
      mem_valid = 1'b0;
      mem_load_data = $urandom();
    end
    if (e) begin
      chk({tag, ".en_cycles"}, 32'(n_en), 32'd0);
      exp_d = 32'h0;
    end else if (waits >= T) begin
      chk({tag, ".en_cycles"}, 32'(n_en), 32'(T));
      e = 1'b1;
      exp_d = 32'h0;
    end else begin
      chk({tag, ".en_cycles"}, 32'(n_en), 32'(waits + 1));
      exp_d = m_is_load(ins) ? m_load(ins, a, w) : 32'h0;
    end
    chk({tag, ".resp_valid"}, 32'(resp_valid), 32'd1);
    chk({tag, ".resp_error"}, 32'(resp_error), 32'(e));
    chk({tag, ".resp_data"}, resp_load_data, exp_d);
    mem_valid = 1'b1;  // stray completion outside ACCESS must be ignored
    @(negedge clk);
    mem_valid = 1'b0;
    chk({tag, ".pulse_end"}, 32'(resp_valid), 32'd0);
    chk({tag, ".hold"}, resp_load_data, exp_d);
    chk({tag, ".idle_en"}, 32'(mem_enable), 32'd0);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst.ready", 32'(req_ready), 32'd1);
    chk("rst.en", 32'(mem_enable), 32'd0);
    chk("rst.rv", 32'(resp_valid), 32'd0);
    chk("rst.re", 32'(resp_error), 32'd0);
    chk("rst.rd", resp_load_data, 32'h0);
    chk("rst.addr", mem_addr, 32'h0);
    chk("rst.mask", 32'(mem_write_mask), 32'h0);
    chk("rst.cmd", 32'(mem_cmd), 32'h0);
    chk("rst.wd", mem_write_data, 32'h0);
    reset = 1'b0;

    run("lw",    mk(7'h03, 3'd2), 32'h14, 32'h0, 2, 32'hDEADBEEF);
    run("sb",    mk(7'h23, 3'd0), 32'h16, 32'h000000A5, 1, 32'h0);
    run("lb",    mk(7'h03, 3'd0), 32'h17, 32'h0, 0, 32'h80FF0000);
    run("lbu",   mk(7'h03, 3'd4), 32'h17, 32'h0, 0, 32'h80FF0000);
    run("lhu",   mk(7'h03, 3'd5), 32'h16, 32'h0, 3, 32'h80FF0000);
    run("lh",    mk(7'h03, 3'd1), 32'h16, 32'h0, 0, 32'h80FF0000);
    run("sh",    mk(7'h23, 3'd1), 32'h22, 32'h1234BEEF, 0, 32'h0);
    run("sw",    mk(7'h23, 3'd2), 32'h40, 32'hCAFEF00D, 4, 32'h0);
    run("lw_mis", mk(7'h03, 3'd2), 32'h15, 32'h0, 0, 32'h0);
    run("sh_mis", mk(7'h23, 3'd1), 32'h31, 32'h0, 0, 32'h0);
    run("ill_f3", mk(7'h03, 3'd3), 32'h20, 32'h0, 0, 32'h0);
    run("ill_op", mk(7'h33, 3'd0), 32'h20, 32'h0, 0, 32'h0);
    run("tmo",   mk(7'h03, 3'd2), 32'h50, 32'h0, 100, 32'h0);
    run("post_tmo", mk(7'h03, 3'd2), 32'h54, 32'h0, 0, 32'h01020304);
    run("last_cyc", mk(7'h03, 3'd2), 32'h58, 32'h0, T - 1, 32'h55AA55AA);

    // Reset during the second ACCESS cycle discards the request.
    @(negedge clk);
    req_valid = 1'b1; req_instr = mk(7'h03, 3'd2); req_addr = 32'h60;
    @(negedge clk);
    req_valid = 1'b0;
    chk("mrst.en1", 32'(mem_enable), 32'd1);
    @(negedge clk);
    chk("mrst.en2", 32'(mem_enable), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("mrst.en", 32'(mem_enable), 32'd0);
    chk("mrst.ready", 32'(req_ready), 32'd1);
    chk("mrst.rv", 32'(resp_valid), 32'd0);
    @(negedge clk);
    chk("mrst.rv2", 32'(resp_valid), 32'd0);

    for (int k = 0; k < 40; k++) begin
      int sel;
      logic [31:0] ins;
      sel = $urandom_range(0, 9);
      case (sel)
        0: ins = mk(7'h03, 3'd0);
        1: ins = mk(7'h03, 3'd1);
        2: ins = mk(7'h03, 3'd2);
        3: ins = mk(7'h03, 3'd4);
        4: ins = mk(7'h03, 3'd5);
        5: ins = mk(7'h23, 3'd0);
        6: ins = mk(7'h23, 3'd1);
        7: ins = mk(7'h23, 3'd2);
        8: ins = mk(7'h03, 3'($urandom_range(6, 7)));
        default: ins = mk(7'($urandom()), 3'($urandom()));
      endcase
      run("rnd", ins, $urandom(), $urandom(), $urandom_range(0, T + 1), $urandom());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
